mlp_stream_tx_ctrl: RTL

- Sequences the per-layer MLP results from the result buffer into the AXI-Stream output master, one word at a time.
- For each layer it reads node results from a synchronous result RAM, pulses the master's write request, and waits for the master's done pulse.
- It drives the current-layer node count to the master so that TLAST lands on the last node of each layer.
- It sits between the layer compute engine, the result RAM and the stream master.

---
 rtl/mlp_stream_tx_ctrl_if.sv | 21 ++
 rtl/mlp_stream_tx_ctrl.sv | 128 ++++++++++++
 2 files changed

// File: rtl/mlp_stream_tx_ctrl_if.sv
// mlp_stream_tx_ctrl_if: result-RAM read port and stream-master write handshake
interface mlp_stream_tx_ctrl_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
);
  logic                  po_rd_en;
  logic [ADDR_WIDTH-1:0] po_rd_addr;
  logic [DATA_WIDTH-1:0] pi_rd_data;
  logic [DATA_WIDTH-1:0] po_mlp_data;
  logic                  po_write_to_fifo;
  logic                  pi_wr_fifo_done;
  logic [9:0]            po_current_layer_nodes;
  modport master (
    output po_rd_en, po_rd_addr, po_mlp_data, po_write_to_fifo, po_current_layer_nodes,
    input  pi_rd_data, pi_wr_fifo_done
  );
  modport slave (
    input  po_rd_en, po_rd_addr, po_mlp_data, po_write_to_fifo, po_current_layer_nodes,
    output pi_rd_data, pi_wr_fifo_done
  );
endinterface

// File: rtl/mlp_stream_tx_ctrl.sv
// mlp_stream_tx_ctrl: streams per-layer MLP results from the result RAM to the stream master
module mlp_stream_tx_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int LAYER_W    = 3
) (
  input  logic               M_AXIS_ACLK,
  input  logic               M_AXIS_ARESETN,
  input  logic               pi_cfg_we,
  input  logic [LAYER_W-1:0] pi_cfg_layer,
  input  logic [9:0]         pi_cfg_nodes,
  input  logic [LAYER_W:0]   pi_num_layers,
  input  logic               pi_start,
  input  logic               pi_layer_valid,
  mlp_stream_tx_ctrl_if.master bus,
  output logic [LAYER_W-1:0] po_layer_idx,
  output logic               po_busy,
  output logic               po_layer_done,
  output logic               po_done,
  output logic               po_overrun
);
  localparam int MAX_LAYERS = 2**LAYER_W;
  typedef enum logic [2:0] {IDLE, WAIT_LAYER, READ, LATCH, WRITE, WAIT_DONE, NEXT} state_t;
  state_t                state_q;
  logic [9:0]            tbl_q [MAX_LAYERS];
  logic [9:0]            nodes_q, cnt_q;
  logic [ADDR_WIDTH-1:0] base_q, addr_q;
  logic [LAYER_W-1:0]    idx_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  flag_q, flag_d, valid_b, consume, last;
  logic                  rd_en_q, wr_q, busy_q, ldone_q, done_q, ovr_q;
  always_comb begin
    valid_b = busy_q && pi_layer_valid;
    consume = state_q == WAIT_LAYER && nodes_q != '0 && (flag_q || pi_layer_valid);
    // a valid arriving while a pending one is consumed stays pending for the next layer
    flag_d  = consume ? flag_q && valid_b : flag_q || valid_b;
    last    = (LAYER_W+1)'(idx_q) + (LAYER_W+1)'(1) == pi_num_layers;
  end
  always_ff @(posedge M_AXIS_ACLK or negedge M_AXIS_ARESETN) begin
    if (!M_AXIS_ARESETN) begin
      state_q <= IDLE;
      for (int i = 0; i < MAX_LAYERS; i++) tbl_q[i] <= '0;
      nodes_q <= '0;
      cnt_q   <= '0;
      base_q  <= '0;
      addr_q  <= '0;
      idx_q   <= '0;
      data_q  <= '0;
      flag_q  <= 1'b0;
      rd_en_q <= 1'b0;
      wr_q    <= 1'b0;
      busy_q  <= 1'b0;
      ldone_q <= 1'b0;
      done_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      rd_en_q <= 1'b0;
      wr_q    <= 1'b0;
      ldone_q <= 1'b0;
      done_q  <= 1'b0;
      ovr_q   <= valid_b && flag_q && !consume;
      flag_q  <= flag_d;
      if (pi_cfg_we && state_q == IDLE) tbl_q[pi_cfg_layer] <= pi_cfg_nodes;
      case (state_q)
        IDLE: if (pi_start) begin
          if (pi_num_layers == '0) done_q <= 1'b1;
          else begin
            idx_q   <= '0;
            base_q  <= '0;
            busy_q  <= 1'b1;
            nodes_q <= tbl_q[0];
            state_q <= WAIT_LAYER;
          end
        end
        WAIT_LAYER: if (nodes_q == '0) begin
          ldone_q <= 1'b1;
          state_q <= NEXT;
        end else if (consume) begin
          cnt_q   <= '0;
          rd_en_q <= 1'b1;
          addr_q  <= base_q;
          state_q <= READ;
        end
        READ: state_q <= LATCH;
        LATCH: begin
          data_q  <= bus.pi_rd_data;
          wr_q    <= 1'b1;
          state_q <= WRITE;
        end
        WRITE: state_q <= WAIT_DONE;
        WAIT_DONE: if (bus.pi_wr_fifo_done) begin
          if (cnt_q == nodes_q - 10'd1) begin
            ldone_q <= 1'b1;
            state_q <= NEXT;
          end else begin
            cnt_q   <= cnt_q + 10'd1;
            rd_en_q <= 1'b1;
            addr_q  <= base_q + ADDR_WIDTH'(cnt_q + 10'd1);
            state_q <= READ;
          end
        end
        NEXT: begin
          base_q <= base_q + ADDR_WIDTH'(nodes_q);
          if (last) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= IDLE;
          end else begin
            idx_q   <= idx_q + LAYER_W'(1);
            nodes_q <= tbl_q[idx_q + LAYER_W'(1)];
            state_q <= WAIT_LAYER;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign bus.po_rd_en               = rd_en_q;
  assign bus.po_rd_addr             = addr_q;
  assign bus.po_mlp_data            = data_q;
  assign bus.po_write_to_fifo       = wr_q;
  assign bus.po_current_layer_nodes = nodes_q;
  assign po_layer_idx               = idx_q;
  assign po_busy                    = busy_q;
  assign po_layer_done              = ldone_q;
  assign po_done                    = done_q;
  assign po_overrun                 = ovr_q;
endmodule
